// File: rtl/mips_soc_top_if.sv
// mips_soc_top_if: debug write-back bundle
// Carries every architectural register write out of the core.
interface mips_soc_top_if;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  modport master (
    output debug_wb_pc,
    output debug_wb_rf_wen,
    output debug_wb_rf_wnum,
    output debug_wb_rf_wdata
  );

  modport slave (
    input debug_wb_pc,
    input debug_wb_rf_wen,
    input debug_wb_rf_wnum,
    input debug_wb_rf_wdata
  );
endinterface

// File: rtl/mips_soc_top.sv
// mips_soc_top: single-cycle MIPS32 subset core
// PC, ROM, regfile, ALU, data RAM; one-slot branch delay.
module mips_soc_top #(
  parameter string       ROM_INIT = "inst_rom.hex",
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic           clk,
  input  logic           rst,
  mips_soc_top_if.master dbg
);

  logic [31:0] rom [1024];
  logic [31:0] ram [1024] = '{default: 32'h0};
  logic [31:0] rf_q [32];

  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        pending_q, pending_d;

  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;
  logic [31:0] rs_v, rt_v, simm, zimm;
  logic [31:0] pc4, addr, ld_v;

  assign instr = rom[pc_q[11:2]];
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign sa    = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];
  assign simm  = {{16{imm[15]}}, imm};
  assign zimm  = {16'h0, imm};
  assign rs_v  = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_v  = (rt == 5'd0) ? 32'h0 : rf_q[rt];
  assign pc4   = pc_q + 32'd4;
  assign addr  = rs_v + simm;
  assign ld_v  = ram[addr[11:2]];

  logic unused_addr;
  assign unused_addr = ^{addr[31:12], addr[1:0]};

  logic        wr, take, st, wen;
  logic [4:0]  wn;
  logic [31:0] wd, tgt;

  // Decode and execute the current instruction.
  always_comb begin
    wr   = 1'b0;
    wn   = 5'd0;
    wd   = 32'h0;
    take = 1'b0;
    tgt  = pc4;
    st   = 1'b0;
    unique case (op)
      6'h00: begin
        wr = 1'b1;
        wn = rd;
        unique case (funct)
          6'h21: wd = rs_v + rt_v;
          6'h23: wd = rs_v - rt_v;
          6'h24: wd = rs_v & rt_v;
          6'h25: wd = rs_v | rt_v;
          6'h26: wd = rs_v ^ rt_v;
          6'h27: wd = ~(rs_v | rt_v);
          6'h2a: wd = {31'h0, $signed(rs_v) < $signed(rt_v)};
          6'h2b: wd = {31'h0, rs_v < rt_v};
          6'h00: wd = rt_v << sa;
          6'h02: wd = rt_v >> sa;
          6'h03: wd = $unsigned($signed(rt_v) >>> sa);
          6'h08: begin
            wr   = 1'b0;
            take = 1'b1;
            tgt  = rs_v;
          end
          default: wr = 1'b0;
        endcase
      end
      6'h09: begin wr = 1'b1; wn = rt; wd = rs_v + simm; end
      6'h0a: begin
        wr = 1'b1;
        wn = rt;
        wd = {31'h0, $signed(rs_v) < $signed(simm)};
      end
      6'h0b: begin wr = 1'b1; wn = rt; wd = {31'h0, rs_v < simm}; end
      6'h0c: begin wr = 1'b1; wn = rt; wd = rs_v & zimm; end
      6'h0d: begin wr = 1'b1; wn = rt; wd = rs_v | zimm; end
      6'h0e: begin wr = 1'b1; wn = rt; wd = rs_v ^ zimm; end
      6'h0f: begin wr = 1'b1; wn = rt; wd = {imm, 16'h0}; end
      6'h23: begin wr = 1'b1; wn = rt; wd = ld_v; end
      6'h2b: st = 1'b1;
      6'h04: begin
        take = (rs_v == rt_v);
        tgt  = pc4 + {simm[29:0], 2'b00};
      end
      6'h05: begin
        take = (rs_v != rt_v);
        tgt  = pc4 + {simm[29:0], 2'b00};
      end
      6'h02: begin
        take = 1'b1;
        tgt  = {pc4[31:28], instr[25:0], 2'b00};
      end
      6'h03: begin
        take = 1'b1;
        tgt  = {pc4[31:28], instr[25:0], 2'b00};
        wr   = 1'b1;
        wn   = 5'd31;
        wd   = pc_q + 32'd8;
      end
      default: ;
    endcase
  end

  assign wen = wr && (wn != 5'd0) && !rst;

  assign dbg.debug_wb_pc       = pc_q;
  assign dbg.debug_wb_rf_wen   = wen;
  assign dbg.debug_wb_rf_wnum  = wen ? wn : 5'd0;
  assign dbg.debug_wb_rf_wdata = wen ? wd : 32'h0;

  assign pc_d      = pending_q ? target_q : pc4;
  assign pending_d = take;
  assign target_d  = tgt;

  // PC and delay-slot tracking; reset cancels a pending branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pending_q <= 1'b0;
      target_q  <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      target_q  <= target_d;
    end
  end

  // Register file write port; reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (wen) begin
      rf_q[wn] <= wd;
    end
  end

  // Data RAM store port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && st) ram[addr[11:2]] <= rt_v;
  end

endmodule

// File: tb/tb_mips_soc_top.sv
// tb_mips_soc_top: directed program with a write-back scoreboard
// Expected trace entries are queued as the program is built.
module tb_mips_soc_top;

  localparam logic [31:0] B = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mips_soc_top_if dbg_if ();

  mips_soc_top #(
    .ROM_INIT (""),
    .RESET_PC (B)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dbg (dbg_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] it(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rt_i(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [5:0] fn
  );
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic put(input int idx, input logic [31:0] w);
    dut.rom[idx] = w;
  endtask

  task automatic push(
    input logic [31:0] pc, input logic wen,
    input logic [4:0] wn, input logic [31:0] wd
  );
    exp_t e;
    e.pc = pc;
    e.wen = wen;
    e.wnum = wn;
    e.wdata = wd;
    sb.push_back(e);
  endtask

  task automatic chk(
    input string tag, input logic [31:0] obs, input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_t e;
    logic [31:0] jal_w;
    for (int i = 0; i < 1024; i++) put(i, 32'h0);
    jal_w = {6'h03, 26'(32'(B + 32'h50) >> 2)};

    put(0,  rt_i(5'd1, 5'd2, 5'd8, 6'h21));
    push(B + 32'h00, 1'b1, 5'd8, 32'h0);
    put(1,  it(6'h0f, 5'd0, 5'd1, 16'h1234));
    push(B + 32'h04, 1'b1, 5'd1, 32'h1234_0000);
    put(2,  it(6'h0d, 5'd1, 5'd1, 16'h5678));
    push(B + 32'h08, 1'b1, 5'd1, 32'h1234_5678);
    put(3,  it(6'h09, 5'd0, 5'd2, 16'hFFFF));
    push(B + 32'h0C, 1'b1, 5'd2, 32'hFFFF_FFFF);
    put(4,  rt_i(5'd1, 5'd2, 5'd3, 6'h2b));
    push(B + 32'h10, 1'b1, 5'd3, 32'h1);
    put(5,  it(6'h2b, 5'd0, 5'd1, 16'h0008));
    push(B + 32'h14, 1'b0, 5'd0, 32'h0);
    put(6,  it(6'h23, 5'd0, 5'd4, 16'h0008));
    push(B + 32'h18, 1'b1, 5'd4, 32'h1234_5678);
    put(7,  it(6'h04, 5'd0, 5'd0, 16'h0002));
    push(B + 32'h1C, 1'b0, 5'd0, 32'h0);
    put(8,  it(6'h09, 5'd0, 5'd5, 16'h0001));
    push(B + 32'h20, 1'b1, 5'd5, 32'h1);
    put(9,  it(6'h09, 5'd0, 5'd6, 16'h0002));
    put(10, it(6'h09, 5'd0, 5'd7, 16'h0003));
    push(B + 32'h28, 1'b1, 5'd7, 32'h3);
    put(11, jal_w);
    push(B + 32'h2C, 1'b1, 5'd31, B + 32'h34);
    put(12, 32'h0);
    push(B + 32'h30, 1'b0, 5'd0, 32'h0);
    put(20, rt_i(5'd31, 5'd0, 5'd0, 6'h08));
    push(B + 32'h50, 1'b0, 5'd0, 32'h0);
    put(21, 32'h0);
    push(B + 32'h54, 1'b0, 5'd0, 32'h0);
    put(13, it(6'h09, 5'd0, 5'd0, 16'h0005));
    push(B + 32'h34, 1'b0, 5'd0, 32'h0);
    put(14, rt_i(5'd0, 5'd0, 5'd11, 6'h21));
    push(B + 32'h38, 1'b1, 5'd11, 32'h0);
    put(15, it(6'h05, 5'd1, 5'd0, 16'h0003));
    push(B + 32'h3C, 1'b0, 5'd0, 32'h0);
    put(16, it(6'h09, 5'd0, 5'd12, 16'h0007));
    put(19, it(6'h09, 5'd0, 5'd13, 16'h0009));

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", dbg_if.debug_wb_pc, B);
    chk("rst_wen", 32'(dbg_if.debug_wb_rf_wen), 32'h0);
    rst = 1'b0;
    #1;

    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc", dbg_if.debug_wb_pc, e.pc);
      chk("wen", 32'(dbg_if.debug_wb_rf_wen), 32'(e.wen));
      chk("wnum", 32'(dbg_if.debug_wb_rf_wnum), 32'(e.wnum));
      chk("wdata", dbg_if.debug_wb_rf_wdata, e.wdata);
      @(negedge clk);
      #1;
    end

    chk("slot_pc", dbg_if.debug_wb_pc, B + 32'h40);
    rst = 1'b1;
    #1;
    chk("slot_rst_wen", 32'(dbg_if.debug_wb_rf_wen), 32'h0);
    chk("slot_rst_pc", dbg_if.debug_wb_pc, B + 32'h40);
    @(negedge clk);
    #1;
    chk("midrst_pc", dbg_if.debug_wb_pc, B);
    chk("midrst_wen", 32'(dbg_if.debug_wb_rf_wen), 32'h0);
    rst = 1'b0;
    #1;
    chk("rerun_wen", 32'(dbg_if.debug_wb_rf_wen), 32'h1);
    chk("rerun_wnum", 32'(dbg_if.debug_wb_rf_wnum), 32'd8);
    chk("rerun_rf_clr", dbg_if.debug_wb_rf_wdata, 32'h0);
    @(negedge clk);
    #1;
    chk("no_target_pc", dbg_if.debug_wb_pc, B + 32'h04);
    chk("rerun_lui", dbg_if.debug_wb_rf_wdata, 32'h1234_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
